mem_fill_arb: RTL and testbench
===============================

MEM_FILL_ARB -- requirements
Module: mem_fill_arb

Interface
REQ-001 Parameters: none; block is 16 bytes (8 x 16-bit words), addresses are 16-bit byte addresses.
REQ-002 clk  in  1  single clock; all state changes on its rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 i_miss  in  1  I-cache miss request; held high until i_fill_done.
REQ-005 i_addr  in  16  I-cache miss byte address; stable while i_miss high.
REQ-006 d_miss  in  1  D-cache miss request; held high until d_fill_done.
REQ-007 d_addr  in  16  D-cache miss byte address; stable while d_miss high.
REQ-008 mem_en  out  1  memory read issue strobe, one word per cycle.
REQ-009 mem_addr  out  16  word address issued with mem_en.
REQ-010 mem_data_valid  in  1  memory return strobe; returns arrive in issue order.
REQ-011 mem_data_in  in  16  returned word, valid with mem_data_valid.
REQ-012 fill_data  out  16  word written into the granted cache data array.
REQ-013 fill_word  out  3  word offset of fill_data within the block.
REQ-014 fill_we_i / fill_we_d  out  1 each  data-array write enable for I / D cache.
REQ-015 tag_we_i / tag_we_d  out  1 each  tag/valid write enable for I / D cache.
REQ-016 i_fill_done / d_fill_done  out  1 each  one-cycle fill-complete pulse.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states IDLE, FILL, DONE; grant register gnt (0=I, 1=D); 12-bit block register blk.
REQ-019 IDLE: if either miss is high, latch winner into gnt, latch winner's addr[15:4] into blk, clear counters, go to FILL next cycle; otherwise stay.
REQ-020 Default arbitration: d_miss wins when both miss inputs are high in the same cycle.
REQ-021 FILL: mem_en high while issue count iss < 8; mem_addr = {blk, iss[2:0], 1'b0}; iss increments each issued cycle, giving exactly 8 consecutive mem_en cycles starting the first FILL cycle.
REQ-022 FILL: each mem_data_valid cycle drives fill_data = mem_data_in, fill_word = receive count rcv, fill_we of gnt high (other cache's enable low), then rcv increments.
REQ-023 mem_data_valid outside FILL is ignored: no write enable, no counter change.
REQ-024 On the 8th received word (rcv = 7 with mem_data_valid) tag_we of gnt pulses in the same cycle as the final fill_we, and FSM moves to DONE.
REQ-025 DONE lasts one cycle: fill_done of gnt high, busy high, then IDLE; requester deasserts its miss the cycle after its fill_done.
REQ-026 A miss of the non-granted cache arriving during FILL/DONE waits; it is arbitrated in the first IDLE cycle.
REQ-027 Miss inputs are not sampled in FILL/DONE; dropping a miss mid-fill does not abort the fill.
REQ-028 All outputs low (mem_addr, fill_data, fill_word zero) whenever their enable is not asserted.

Reset
REQ-029 rst forces state IDLE, gnt=0, blk=0, iss=0, rcv=0, last-winner=I, all outputs 0 in the cycle after rst is sampled.
REQ-030 rst mid-FILL abandons the fill: no tag_we, no fill_done; returns still in flight after reset are ignored per REQ-023.

Configuration
REQ-031 Macro FILL_ARB_RR_EN: when defined, simultaneous misses grant the cache that did not win the previous grant (round-robin, initial preference D); when undefined, fixed D priority per REQ-020.

Verification
REQ-032 i_miss=1, i_addr=16'h1234, memory latency 4 -> mem_en cycles 1..8 with mem_addr 16'h1230,1232,...,123E; fill_we_i 8 times, fill_word 0..7; tag_we_i with 8th word; i_fill_done 1 cycle later; busy low after.
REQ-033 i_miss and d_miss rise same cycle (d_addr=16'h8000) -> D filled first (mem_addr 16'h8000..800E), then I fill starts in the IDLE cycle after d_fill_done.
REQ-034 FILL_ARB_RR_EN defined, two back-to-back simultaneous miss pairs -> grant order D, I, D, I; undefined -> D, I, D, I only because of waiting, with D first each simultaneous IDLE.
REQ-035 rst asserted after 3rd returned word -> next cycle busy=0, no tag_we/fill_done; remaining mem_data_valid pulses produce no fill_we; fresh miss then fills from word 0.
REQ-036 mem_data_valid pulsed while IDLE with no miss -> no write enables, counters unchanged, busy=0.

Source files
------------

// File: rtl/mem_fill_arb_if.sv
// rtl/mem_fill_arb_if.sv - cache-miss / memory-read / fill-port bundle for mem_fill_arb
interface mem_fill_arb_if;
    logic        i_miss;
    logic [15:0] i_addr;
    logic        d_miss;
    logic [15:0] d_addr;
    logic        mem_en;
    logic [15:0] mem_addr;
    logic        mem_data_valid;
    logic [15:0] mem_data_in;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        fill_we_i;
    logic        fill_we_d;
    logic        tag_we_i;
    logic        tag_we_d;
    logic        i_fill_done;
    logic        d_fill_done;
    logic        busy;

    modport master (
        input  i_miss, i_addr, d_miss, d_addr, mem_data_valid, mem_data_in,
        output mem_en, mem_addr, fill_data, fill_word, fill_we_i, fill_we_d,
               tag_we_i, tag_we_d, i_fill_done, d_fill_done, busy
    );

    modport slave (
        output i_miss, i_addr, d_miss, d_addr, mem_data_valid, mem_data_in,
        input  mem_en, mem_addr, fill_data, fill_word, fill_we_i, fill_we_d,
               tag_we_i, tag_we_d, i_fill_done, d_fill_done, busy
    );
endinterface

// File: rtl/mem_fill_arb.sv
// rtl/mem_fill_arb.sv - I/D cache line-fill arbiter, 8 x 16-bit words per block
// Optional FILL_ARB_RR_EN: round-robin on simultaneous misses (default fixed D priority).
module mem_fill_arb (
    input  logic          clk,
    input  logic          rst,
    mem_fill_arb_if.master fill_bus
);
    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

`ifdef FILL_ARB_RR_EN
    localparam logic RR_EN = 1'b1;
`else
    localparam logic RR_EN = 1'b0;
`endif

    state_t      r_state, w_state_nxt;
    logic        r_gnt, w_gnt_nxt;
    logic [11:0] r_blk, w_blk_nxt;
    logic [3:0]  r_iss, w_iss_nxt;
    logic [2:0]  r_rcv, w_rcv_nxt;
    logic        r_last, w_last_nxt;

    logic        w_prefer_d;
    logic        w_pick_d;
    logic        w_any_miss;
    logic        w_issue;
    logic        w_recv;
    logic        w_last_word;
    logic        w_done;

    // r_last holds the previous winner (1 = D); initial value I makes D the first preference
    assign w_prefer_d  = ~RR_EN | ~r_last;
    assign w_any_miss  = fill_bus.i_miss | fill_bus.d_miss;
    assign w_pick_d    = fill_bus.d_miss & (~fill_bus.i_miss | w_prefer_d);
    assign w_issue     = (r_state == S_FILL) & ~r_iss[3];
    assign w_recv      = (r_state == S_FILL) & fill_bus.mem_data_valid;
    assign w_last_word = w_recv & (r_rcv == 3'd7);
    assign w_done      = (r_state == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_gnt   <= 1'b0;
            r_blk   <= '0;
            r_iss   <= '0;
            r_rcv   <= '0;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_blk   <= w_blk_nxt;
            r_iss   <= w_iss_nxt;
            r_rcv   <= w_rcv_nxt;
            r_last  <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_blk_nxt   = r_blk;
        w_iss_nxt   = r_iss;
        w_rcv_nxt   = r_rcv;
        w_last_nxt  = r_last;
        case (r_state)
            S_IDLE: begin
                if (w_any_miss) begin
                    w_state_nxt = S_FILL;
                    w_gnt_nxt   = w_pick_d;
                    w_blk_nxt   = w_pick_d ? fill_bus.d_addr[15:4] : fill_bus.i_addr[15:4];
                    w_iss_nxt   = '0;
                    w_rcv_nxt   = '0;
                    w_last_nxt  = w_pick_d;
                end
            end
            S_FILL: begin
                if (w_issue) begin
                    w_iss_nxt = r_iss + 4'd1;
                end
                if (w_recv) begin
                    w_rcv_nxt = r_rcv + 3'd1;
                    if (r_rcv == 3'd7) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // every data output is forced to zero unless its enable is active
    assign fill_bus.mem_en      = w_issue;
    assign fill_bus.mem_addr    = w_issue ? {r_blk, r_iss[2:0], 1'b0} : 16'd0;
    assign fill_bus.fill_data   = w_recv ? fill_bus.mem_data_in : 16'd0;
    assign fill_bus.fill_word   = w_recv ? r_rcv : 3'd0;
    assign fill_bus.fill_we_i   = w_recv & ~r_gnt;
    assign fill_bus.fill_we_d   = w_recv & r_gnt;
    assign fill_bus.tag_we_i    = w_last_word & ~r_gnt;
    assign fill_bus.tag_we_d    = w_last_word & r_gnt;
    assign fill_bus.i_fill_done = w_done & ~r_gnt;
    assign fill_bus.d_fill_done = w_done & r_gnt;
    assign fill_bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_fill_arb.sv
// tb/tb_mem_fill_arb.sv - directed self-checking bench for mem_fill_arb
module tb_mem_fill_arb;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    mem_fill_arb_if fb();
    mem_fill_arb dut (.clk(clk), .rst(rst), .fill_bus(fb));

    // memory: fixed 4-cycle latency, data = address ^ 16'h5A5A
    logic [3:0]  pv = '0;
    logic [15:0] pd [4];
    logic        man_v;
    logic [15:0] man_d;
    always @(posedge clk) begin
        pv    <= {pv[2:0], fb.mem_en};
        pd[0] <= fb.mem_addr ^ 16'h5A5A;
        pd[1] <= pd[0];
        pd[2] <= pd[1];
        pd[3] <= pd[2];
    end
    assign fb.mem_data_valid = pv[3] | man_v;
    assign fb.mem_data_in    = pv[3] ? pd[3] : man_d;

    int          cyc  = 0;
    int          viol = 0;
    logic [15:0] q_addr[$];
    int          q_en_cyc[$];
    logic [19:0] q_fill[$];
    int          q_fill_cyc[$];
    logic        q_tag[$];
    int          q_tag_cyc[$];
    logic        q_done[$];
    int          q_done_cyc[$];

    always @(negedge clk) begin
        cyc++;
        if (fb.mem_en === 1'b1) begin
            q_addr.push_back(fb.mem_addr);
            q_en_cyc.push_back(cyc);
        end else if (fb.mem_addr !== 16'd0 && rst === 1'b0) viol++;
        if ((fb.fill_we_i | fb.fill_we_d) === 1'b1) begin
            q_fill.push_back({fb.fill_we_d, fb.fill_word, fb.fill_data});
            q_fill_cyc.push_back(cyc);
        end else if ((fb.fill_data !== 16'd0 || fb.fill_word !== 3'd0) && rst === 1'b0) viol++;
        if ((fb.fill_we_i & fb.fill_we_d) === 1'b1) viol++;
        if ((fb.tag_we_i | fb.tag_we_d) === 1'b1) begin
            q_tag.push_back(fb.tag_we_d);
            q_tag_cyc.push_back(cyc);
        end
        if ((fb.i_fill_done | fb.d_fill_done) === 1'b1) begin
            q_done.push_back(fb.d_fill_done);
            q_done_cyc.push_back(cyc);
            if ((fb.i_fill_done & fb.d_fill_done) === 1'b1) viol++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_addr.delete(); q_en_cyc.delete(); q_fill.delete(); q_fill_cyc.delete();
        q_tag.delete(); q_tag_cyc.delete(); q_done.delete(); q_done_cyc.delete();
    endtask

    // drop each miss the cycle after its fill_done; returns once both are low
    task automatic serve(input int budget, output bit ok);
        bit di, ii;
        int n = 0;
        while ((fb.i_miss | fb.d_miss) && n < budget) begin
            @(negedge clk);
            di = fb.d_fill_done;
            ii = fb.i_fill_done;
            @(posedge clk);
            #1;
            if (di) fb.d_miss = 1'b0;
            if (ii) fb.i_miss = 1'b0;
            n++;
        end
        ok = !(fb.i_miss | fb.d_miss);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        fb.i_miss = 0; fb.d_miss = 0; fb.i_addr = 0; fb.d_addr = 0;
        man_v = 0; man_d = 0;
        repeat (3) step();
        rst = 1'b0;
        clear_q();
        viol = 0;
        @(negedge clk);
        total++;
        if ({fb.busy, fb.mem_en, fb.fill_we_i, fb.fill_we_d} !== 4'b0) begin
            bad++; $display("FAIL reset_ctrl got=%b want=0000", {fb.busy, fb.mem_en, fb.fill_we_i, fb.fill_we_d});
        end
        total++;
        if ({fb.tag_we_i, fb.tag_we_d, fb.i_fill_done, fb.d_fill_done} !== 4'b0) begin
            bad++; $display("FAIL reset_pulses got=%b want=0000", {fb.tag_we_i, fb.tag_we_d, fb.i_fill_done, fb.d_fill_done});
        end
        total++;
        if ({fb.mem_addr, fb.fill_data, fb.fill_word} !== 35'd0) begin
            bad++; $display("FAIL reset_data got=%h want=0", {fb.mem_addr, fb.fill_data, fb.fill_word});
        end
    endtask

    task automatic test_single_i();
        bit ok;
        logic [15:0] ea;
        step();
        clear_q();
        fb.i_miss = 1; fb.i_addr = 16'h1234;
        @(negedge clk);
        total++;
        if ({fb.busy, fb.mem_en} !== 2'b00) begin
            bad++; $display("FAIL single_idle got=%b want=00", {fb.busy, fb.mem_en});
        end
        @(negedge clk);
        total++;
        if (fb.mem_en !== 1'b1 || fb.mem_addr !== 16'h1230) begin
            bad++; $display("FAIL single_first_issue got=%b/%h want=1/1230", fb.mem_en, fb.mem_addr);
        end
        serve(60, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL single_timeout got=no_done want=i_fill_done"); end
        @(negedge clk);
        total++;
        if (fb.busy !== 1'b0) begin bad++; $display("FAIL single_busy_after got=%b want=0", fb.busy); end
        total++;
        if (q_addr.size() != 8 || q_fill.size() != 8) begin
            bad++; $display("FAIL single_counts got=%0d/%0d want=8/8", q_addr.size(), q_fill.size());
        end
        for (int k = 0; k < 8 && k < q_addr.size() && k < q_fill.size(); k++) begin
            ea = 16'h1230 + 16'(2 * k);
            total++;
            if (q_addr[k] !== ea || q_en_cyc[k] - q_en_cyc[0] != k) begin
                bad++; $display("FAIL single_issue[%0d] got=%h@%0d want=%h@%0d", k, q_addr[k], q_en_cyc[k] - q_en_cyc[0], ea, k);
            end
            total++;
            if (q_fill[k] !== {1'b0, 3'(k), ea ^ 16'h5A5A}) begin
                bad++; $display("FAIL single_fill[%0d] got=%h want=%h", k, q_fill[k], {1'b0, 3'(k), ea ^ 16'h5A5A});
            end
        end
        total++;
        if (q_fill_cyc.size() == 0 || q_en_cyc.size() == 0 || q_fill_cyc[0] - q_en_cyc[0] != 4) begin
            bad++; $display("FAIL single_latency got=%0d want=4", (q_fill_cyc.size() > 0 && q_en_cyc.size() > 0) ? q_fill_cyc[0] - q_en_cyc[0] : -1);
        end
        total++;
        if (q_tag.size() != 1 || q_fill_cyc.size() != 8 || q_tag[0] !== 1'b0 || q_tag_cyc[0] != q_fill_cyc[7]) begin
            bad++; $display("FAIL single_tag got=%0d tags want=1 tag_we_i with word 7", q_tag.size());
        end
        total++;
        if (q_done.size() != 1 || q_tag.size() != 1 || q_done[0] !== 1'b0 || q_done_cyc[0] != q_tag_cyc[0] + 1) begin
            bad++; $display("FAIL single_done got=%0d dones want=1 i_fill_done one cycle after tag", q_done.size());
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        step();
        clear_q();
        fb.i_miss = 1; fb.i_addr = 16'h4560;
        fb.d_miss = 1; fb.d_addr = 16'h8000;
        serve(120, ok);
        total++;
        if (!ok) begin bad++; $display("FAIL simul_timeout got=pending want=both_done"); end
        total++;
        if (q_addr.size() != 16 || q_fill.size() != 16) begin
            bad++; $display("FAIL simul_counts got=%0d/%0d want=16/16", q_addr.size(), q_fill.size());
        end
        for (int k = 0; k < 8 && q_addr.size() == 16 && q_fill.size() == 16; k++) begin
            total++;
            if (q_addr[k] !== 16'h8000 + 16'(2 * k) || q_addr[8 + k] !== 16'h4560 + 16'(2 * k)) begin
                bad++; $display("FAIL simul_addr[%0d] got=%h/%h want=%h/%h", k, q_addr[k], q_addr[8 + k], 16'h8000 + 16'(2 * k), 16'h4560 + 16'(2 * k));
            end
            total++;
            if (q_fill[k][19] !== 1'b1 || q_fill[8 + k][19] !== 1'b0) begin
                bad++; $display("FAIL simul_cache[%0d] got=%b%b want=10", k, q_fill[k][19], q_fill[8 + k][19]);
            end
        end
        total++;
        if (q_done.size() != 2 || q_done[0] !== 1'b1 || q_done[1] !== 1'b0) begin
            bad++; $display("FAIL simul_done_order got=%0d dones want=D,I", q_done.size());
        end
        total++;
        if (q_done.size() < 1 || q_en_cyc.size() < 9 || q_en_cyc[8] - q_done_cyc[0] != 2) begin
            bad++; $display("FAIL simul_i_start got=%0d want=2", (q_done.size() > 0 && q_en_cyc.size() > 8) ? q_en_cyc[8] - q_done_cyc[0] : -1);
        end
    endtask

    task automatic test_arb_order();
        bit ok1, ok2;
        logic exp_second;
        step();
        clear_q();
        fb.i_miss = 1; fb.i_addr = 16'h1000; fb.d_miss = 1; fb.d_addr = 16'h2000;
        serve(120, ok1);
        fb.i_miss = 1; fb.i_addr = 16'h3000; fb.d_miss = 1; fb.d_addr = 16'h4000;
        serve(120, ok2);
        total++;
        if (!(ok1 && ok2) || q_done.size() != 4 ||
            {q_done[0], q_done[1], q_done[2], q_done[3]} !== 4'b1010) begin
            bad++; $display("FAIL pair_order got=%0d dones want=D,I,D,I", q_done.size());
        end
        clear_q();
        fb.d_miss = 1; fb.d_addr = 16'h5000;
        serve(60, ok1);
        fb.i_miss = 1; fb.i_addr = 16'h6000; fb.d_miss = 1; fb.d_addr = 16'h7000;
        serve(120, ok2);
`ifdef FILL_ARB_RR_EN
        exp_second = 1'b0;
`else
        exp_second = 1'b1;
`endif
        total++;
        if (!(ok1 && ok2) || q_done.size() != 3 || q_done[0] !== 1'b1 || q_done[1] !== exp_second) begin
            bad++; $display("FAIL after_d_winner got=%b want=%b", (q_done.size() > 1) ? q_done[1] : 1'bx, exp_second);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int seen = 0;
        step();
        clear_q();
        fb.d_miss = 1; fb.d_addr = 16'hABC0;
        for (int n = 0; n < 40 && seen < 3; n++) begin
            @(negedge clk);
            if (fb.fill_we_d === 1'b1) seen++;
        end
        total++;
        if (seen != 3) begin bad++; $display("FAIL rstmid_words got=%0d want=3", seen); end
        @(posedge clk); #1;
        rst = 1'b1; fb.d_miss = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        clear_q();
        @(negedge clk);
        total++;
        if ({fb.busy, fb.tag_we_d, fb.d_fill_done, fb.fill_we_d} !== 4'b0) begin
            bad++; $display("FAIL rstmid_after got=%b want=0000", {fb.busy, fb.tag_we_d, fb.d_fill_done, fb.fill_we_d});
        end
        repeat (10) step();
        total++;
        if (q_fill.size() != 0 || q_tag.size() != 0 || q_done.size() != 0 || q_addr.size() != 0) begin
            bad++; $display("FAIL rstmid_stale got=%0d/%0d/%0d/%0d want=0/0/0/0", q_fill.size(), q_tag.size(), q_done.size(), q_addr.size());
        end
        fb.d_miss = 1; fb.d_addr = 16'h0100;
        serve(60, ok);
        total++;
        if (!ok || q_fill.size() != 8 || q_tag.size() != 1 || q_done.size() != 1) begin
            bad++; $display("FAIL rstmid_refill got=%0d words want=8", q_fill.size());
        end
        for (int k = 0; k < 8 && k < q_fill.size(); k++) begin
            total++;
            if (q_fill[k] !== {1'b1, 3'(k), (16'h0100 + 16'(2 * k)) ^ 16'h5A5A}) begin
                bad++; $display("FAIL rstmid_word[%0d] got=%h want=%h", k, q_fill[k], {1'b1, 3'(k), (16'h0100 + 16'(2 * k)) ^ 16'h5A5A});
            end
        end
    endtask

    task automatic test_idle_valid();
        bit ok;
        step();
        clear_q();
        man_v = 1; man_d = 16'hBEEF;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            total++;
            if ({fb.fill_we_i, fb.fill_we_d, fb.busy} !== 3'b0 || fb.fill_data !== 16'd0) begin
                bad++; $display("FAIL idle_valid[%0d] got=%b/%h want=000/0000", n, {fb.fill_we_i, fb.fill_we_d, fb.busy}, fb.fill_data);
            end
            @(posedge clk); #1;
        end
        man_v = 0;
        fb.i_miss = 1; fb.i_addr = 16'h0040;
        serve(60, ok);
        total++;
        if (!ok || q_fill.size() != 8) begin
            bad++; $display("FAIL idle_refill got=%0d words want=8", q_fill.size());
        end
        for (int k = 0; k < 8 && k < q_fill.size(); k++) begin
            total++;
            if (q_fill[k] !== {1'b0, 3'(k), (16'h0040 + 16'(2 * k)) ^ 16'h5A5A}) begin
                bad++; $display("FAIL idle_word[%0d] got=%h want=%h", k, q_fill[k], {1'b0, 3'(k), (16'h0040 + 16'(2 * k)) ^ 16'h5A5A});
            end
        end
    endtask

    task automatic test_output_gating();
        total++;
        if (viol != 0) begin bad++; $display("FAIL output_gating got=%0d violations want=0", viol); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_i();
        test_simultaneous();
        test_arb_order();
        test_reset_mid();
        test_idle_valid();
        test_output_gating();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
